// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache port arbiter: FSM states, grant
// encoding and default bus widths.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // Encoding of the round-robin "last granted" bit.
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between the fetch and data requesters; the
// requester that was not granted last wins a tie.
module rr_arbiter2
    import cache_arb_pkg::*;
(
    input  logic en,
    input  logic req_i,
    input  logic req_d,
    input  logic last,
    output logic grant_i,
    output logic grant_d
);

    logic contend;

    assign contend = req_i && req_d;

    // Under contention, the side opposite to `last` wins; otherwise any lone
    // requester is granted.
    assign grant_i = en && req_i && (!contend || (last == GNT_D));
    assign grant_d = en && req_d && (!contend || (last == GNT_I));

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the single cache_controller port between instruction fetch and data
// memory: one registered transaction at a time, held through c_stall.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int STALL_MAX = 64
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rsp_valid,
    output logic [DATA_W-1:0] i_rsp_data,

    input  logic              d_valid,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,

    output logic              c_read,
    output logic              c_write,
    output logic [ADDR_W-1:0] c_adr,
    output logic [DATA_W-1:0] c_wdata,
    input  logic              c_stall,
    input  logic [DATA_W-1:0] c_rdata,

    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALL_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_MAX - 1);

    arb_state_t       state;
    logic             last;
    logic [CNT_W-1:0] stall_cnt;
    logic             grant_i;
    logic             grant_d;

    rr_arbiter2 u_rr (
        .en      (state == IDLE),
        .req_i   (i_valid),
        .req_d   (d_valid),
        .last    (last),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    assign i_ready = grant_i;
    assign d_ready = grant_d;
    assign busy    = (state != IDLE);

    // NOTE: every register below is updated with <= so all of them sample the
    // pre-edge values of state/stall_cnt; blocking assignments would let later
    // statements see half-updated state and change behaviour with statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            last        <= GNT_I;
            stall_cnt   <= '0;
            err         <= 1'b0;
            c_read      <= 1'b0;
            c_write     <= 1'b0;
            c_adr       <= '0;
            c_wdata     <= '0;
            i_rsp_valid <= 1'b0;
            i_rsp_data  <= '0;
            d_rsp_valid <= 1'b0;
            d_rsp_data  <= '0;
        end else begin
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (grant_i) begin
                        state   <= BUSY_I;
                        last    <= GNT_I;
                        c_adr   <= i_addr;
                        c_wdata <= '0;
                        c_read  <= 1'b1;
                        c_write <= 1'b0;
                    end else if (grant_d) begin
                        state   <= BUSY_D;
                        last    <= GNT_D;
                        c_adr   <= d_addr;
                        c_wdata <= d_wdata;
                        c_read  <= !d_write;
                        c_write <= d_write;
                    end
                end

                BUSY_I, BUSY_D: begin
                    if (c_stall) begin
                        // Saturating count; err latches at the edge the count
                        // reaches STALL_MAX, and the access keeps waiting.
                        if (stall_cnt != CNT_MAX)
                            stall_cnt <= stall_cnt + 1'b1;
                        if (stall_cnt >= CNT_LAST)
                            err <= 1'b1;
                    end else begin
                        stall_cnt <= '0;
                        state     <= IDLE;
                        c_read    <= 1'b0;
                        c_write   <= 1'b0;
                        if (state == BUSY_I) begin
                            i_rsp_valid <= 1'b1;
                            i_rsp_data  <= c_rdata;
                        end else begin
                            d_rsp_valid <= 1'b1;
                            d_rsp_data  <= c_write ? '0 : c_rdata;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed, table-driven bench for cache_port_arbiter plus hand-written
// sequences for contention, watchdog, reset and back-to-back cases.
module tb_cache_port_arbiter;

    logic        CLK;
    logic        RST;
    logic        i_valid;
    logic [9:0]  i_addr;
    logic        i_ready;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        d_valid;
    logic        d_write;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        c_read;
    logic        c_write;
    logic [9:0]  c_adr;
    logic [31:0] c_wdata;
    logic        c_stall;
    logic [31:0] c_rdata;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    cache_port_arbiter #(.ADDR_W(10), .DATA_W(32), .STALL_MAX(64)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_valid     (i_valid),
        .i_addr      (i_addr),
        .i_ready     (i_ready),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_data  (i_rsp_data),
        .d_valid     (d_valid),
        .d_write     (d_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_ready     (d_ready),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_data  (d_rsp_data),
        .c_read      (c_read),
        .c_write     (c_write),
        .c_adr       (c_adr),
        .c_wdata     (c_wdata),
        .c_stall     (c_stall),
        .c_rdata     (c_rdata),
        .busy        (busy),
        .err         (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        iv;
        logic [9:0]  ia;
        logic        dv;
        logic        dw;
        logic [9:0]  da;
        logic [31:0] dwd;
        logic [31:0] rdata;
        int          nstall;
        logic        exp_ir;
        logic        exp_dr;
        logic        exp_cr;
        logic        exp_cw;
        logic [9:0]  exp_adr;
        logic [31:0] exp_wd;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " i_ready"},     32'(i_ready),     32'd0);
        check({tag, " d_ready"},     32'(d_ready),     32'd0);
        check({tag, " i_rsp_valid"}, 32'(i_rsp_valid), 32'd0);
        check({tag, " i_rsp_data"},  i_rsp_data,       32'd0);
        check({tag, " d_rsp_valid"}, 32'(d_rsp_valid), 32'd0);
        check({tag, " d_rsp_data"},  d_rsp_data,       32'd0);
        check({tag, " c_read"},      32'(c_read),      32'd0);
        check({tag, " c_write"},     32'(c_write),     32'd0);
        check({tag, " c_adr"},       32'(c_adr),       32'd0);
        check({tag, " c_wdata"},     c_wdata,          32'd0);
        check({tag, " busy"},        32'(busy),        32'd0);
        check({tag, " err"},         32'(err),         32'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        c_stall = 1'b0; c_rdata = '0;
        step();
        step();
        RST = 1'b0;
    endtask

    initial begin
        //            iv  ia      dv  dw  da      dwd            rdata          ns ir  dr  cr  cw  adr     wd             rsp
        vecs[0] = '{1'b1, 10'h014, 1'b0, 1'b0, 10'h000, 32'h0,        32'hDEADBEEF, 0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h014, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h000, 32'h5,        32'h12345678, 3, 1'b0, 1'b1, 1'b0, 1'b1, 10'h000, 32'h5,        32'h0};
        vecs[2] = '{1'b1, 10'h3FF, 1'b1, 1'b0, 10'h155, 32'h0,        32'h000000A5, 1, 1'b1, 1'b0, 1'b1, 1'b0, 10'h3FF, 32'h0,        32'h000000A5};
        vecs[3] = '{1'b1, 10'h0AA, 1'b1, 1'b0, 10'h2AA, 32'h0,        32'hCAFEF00D, 0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h2AA, 32'h0,        32'hCAFEF00D};
        vecs[4] = '{1'b1, 10'h001, 1'b1, 1'b1, 10'h100, 32'h77,       32'h00000001, 2, 1'b1, 1'b0, 1'b1, 1'b0, 10'h001, 32'h0,        32'h00000001};
        vecs[5] = '{1'b1, 10'h002, 1'b1, 1'b1, 10'h200, 32'hFFFFFFFF, 32'h0BADF00D, 0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h200, 32'hFFFFFFFF, 32'h0};

        // Reset state.
        do_reset();
        check_all_zero("reset");

        // Continuous contention right after reset: D, I, D, I.
        begin
            logic [3:0] gnt_d_seq;
            gnt_d_seq = 4'b0101;  // bit j = 1 means grant j goes to D
            i_valid = 1'b1; i_addr = 10'h040;
            d_valid = 1'b1; d_write = 1'b0; d_addr = 10'h080;
            c_stall = 1'b0; c_rdata = 32'h0000_1111;
            for (int j = 0; j < 4; j++) begin
                #1;
                check($sformatf("rr%0d d_ready", j), 32'(d_ready), 32'(gnt_d_seq[j]));
                check($sformatf("rr%0d i_ready", j), 32'(i_ready), 32'(!gnt_d_seq[j]));
                if (j > 0)
                    check($sformatf("rr%0d prev d_rsp_valid", j), 32'(d_rsp_valid), 32'(gnt_d_seq[j-1]));
                step();
                check($sformatf("rr%0d busy ready_i", j), 32'(i_ready), 32'd0);
                check($sformatf("rr%0d busy ready_d", j), 32'(d_ready), 32'd0);
                check($sformatf("rr%0d c_adr", j), 32'(c_adr), gnt_d_seq[j] ? 32'h080 : 32'h040);
                step();
            end
            i_valid = 1'b0; d_valid = 1'b0;
            #1;
            check("rr last i_rsp_valid", 32'(i_rsp_valid), 32'd1);
            step();
        end

        // Table-driven single transactions.
        for (int v = 0; v < 6; v++) begin
            i_valid = vecs[v].iv; i_addr = vecs[v].ia;
            d_valid = vecs[v].dv; d_write = vecs[v].dw;
            d_addr = vecs[v].da;  d_wdata = vecs[v].dwd;
            c_rdata = vecs[v].rdata;
            c_stall = (vecs[v].nstall > 0);
            #1;
            check($sformatf("v%0d i_ready", v), 32'(i_ready), 32'(vecs[v].exp_ir));
            check($sformatf("v%0d d_ready", v), 32'(d_ready), 32'(vecs[v].exp_dr));
            step();
            i_valid = 1'b0; d_valid = 1'b0;
            for (int k = 0; k <= vecs[v].nstall; k++) begin
                c_stall = (k < vecs[v].nstall);
                #1;
                check($sformatf("v%0d.%0d c_read", v, k),  32'(c_read),  32'(vecs[v].exp_cr));
                check($sformatf("v%0d.%0d c_write", v, k), 32'(c_write), 32'(vecs[v].exp_cw));
                check($sformatf("v%0d.%0d c_adr", v, k),   32'(c_adr),   32'(vecs[v].exp_adr));
                if (vecs[v].exp_cw)
                    check($sformatf("v%0d.%0d c_wdata", v, k), c_wdata, vecs[v].exp_wd);
                check($sformatf("v%0d.%0d busy", v, k), 32'(busy), 32'd1);
                check($sformatf("v%0d.%0d no rsp", v, k), 32'({i_rsp_valid, d_rsp_valid}), 32'd0);
                step();
            end
            c_stall = 1'b0;
            check($sformatf("v%0d i_rsp_valid", v), 32'(i_rsp_valid), 32'(vecs[v].exp_ir));
            check($sformatf("v%0d d_rsp_valid", v), 32'(d_rsp_valid), 32'(vecs[v].exp_dr));
            if (vecs[v].exp_ir)
                check($sformatf("v%0d i_rsp_data", v), i_rsp_data, vecs[v].exp_rsp);
            else
                check($sformatf("v%0d d_rsp_data", v), d_rsp_data, vecs[v].exp_rsp);
            check($sformatf("v%0d idle busy", v), 32'(busy), 32'd0);
            check($sformatf("v%0d idle cmd", v), 32'({c_read, c_write}), 32'd0);
            step();
            check($sformatf("v%0d rsp pulse", v), 32'({i_rsp_valid, d_rsp_valid}), 32'd0);
        end

        // Watchdog: 64 consecutive stalled cycles set err; completion still happens.
        i_valid = 1'b1; i_addr = 10'h123; c_stall = 1'b1; c_rdata = 32'h600D_F00D;
        step();
        i_valid = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            step();
            if (n == 63 || n == 64 || n == 70)
                check($sformatf("wd err after %0d stalls", n), 32'(err), (n >= 64) ? 32'd1 : 32'd0);
            if (n == 70)
                check("wd still busy", 32'(busy), 32'd1);
        end
        c_stall = 1'b0;
        step();
        check("wd i_rsp_valid", 32'(i_rsp_valid), 32'd1);
        check("wd i_rsp_data", i_rsp_data, 32'h600D_F00D);
        check("wd err kept", 32'(err), 32'd1);
        step();
        check("wd err sticky", 32'(err), 32'd1);

        // Reset during a stalled store drops it without a response.
        d_valid = 1'b1; d_write = 1'b1; d_addr = 10'h3C0; d_wdata = 32'hA5A5_A5A5;
        c_stall = 1'b1;
        step();
        d_valid = 1'b0;
        step();
        step();
        check("mid busy before rst", 32'(busy), 32'd1);
        RST = 1'b1;
        step();
        check_all_zero("midrst");
        RST = 1'b0;
        c_stall = 1'b0;
        step();
        check("midrst no d_rsp", 32'(d_rsp_valid), 32'd0);
        check("midrst idle", 32'(busy), 32'd0);

        // Fetch presented in the d_rsp_valid cycle is granted immediately.
        d_valid = 1'b1; d_write = 1'b0; d_addr = 10'h0F0; c_rdata = 32'h1357_9BDF;
        step();
        d_valid = 1'b0;
        step();
        i_valid = 1'b1; i_addr = 10'h2F0;
        #1;
        check("b2b d_rsp_valid", 32'(d_rsp_valid), 32'd1);
        check("b2b d_rsp_data", d_rsp_data, 32'h1357_9BDF);
        check("b2b i_ready", 32'(i_ready), 32'd1);
        c_rdata = 32'h2468_ACE0;
        step();
        i_valid = 1'b0;
        check("b2b c_read", 32'(c_read), 32'd1);
        check("b2b c_adr", 32'(c_adr), 32'h2F0);
        step();
        check("b2b i_rsp_valid", 32'(i_rsp_valid), 32'd1);
        check("b2b i_rsp_data", i_rsp_data, 32'h2468_ACE0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
